// File: rtl/ps2_rx_pkg.sv
// ps2_rx_pkg: shared FSM states, frame constants and default timing parameters
package ps2_rx_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PARITY = 2'd2, STOP = 2'd3} state_t;
    localparam int DATA_BITS       = 8;
    localparam int FILT_CYC_DEF    = 16;
    localparam int TIMEOUT_CYC_DEF = 216000;
endpackage

// File: rtl/ps2_filt.sv
// ps2_filt: 2-flop synchronizer plus persistence filter for one async PS/2 line
module ps2_filt #(
    parameter int FILT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
);
    localparam int CW = $clog2(FILT_CYC + 1);
    logic          r_s1;
    logic          r_s2;
    logic          r_out;
    logic [CW-1:0] r_cnt;
    // synchronize, then flip the output only after FILT_CYC consecutive differing samples
    always_ff @(posedge clk) begin
        if (rst) begin
            {r_s1, r_s2, r_out} <= 3'b111;
            r_cnt <= '0;
        end else begin
            r_s1 <= in;
            r_s2 <= r_s1;
            if (r_s2 == r_out) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT_CYC - 1)) begin
                r_out <= ~r_out;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign out = r_out;
endmodule

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver producing validated scan-code bytes
module ps2_rx
    import ps2_rx_pkg::*;
#(
    parameter int FILT_CYC    = FILT_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [7:0]  data,
    output logic        valid,
    output logic        err_par,
    output logic        err_frm,
    output logic        busy,
    output logic [15:0] last
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    logic          w_clk;
    logic          w_dat;
    logic          w_fall;
    logic          w_to;
    logic          r_clk_d;
    state_t        r_state;
    state_t        w_state_n;
    logic [7:0]    r_sr;
    logic [7:0]    w_sr_n;
    logic [2:0]    r_cnt;
    logic [2:0]    w_cnt_n;
    logic          r_p;
    logic          w_p_n;
    logic [TW-1:0] r_tcnt;
    logic          w_valid_n;
    logic          w_perr_n;
    logic          w_ferr_n;

    ps2_filt #(.FILT_CYC(FILT_CYC)) u_filt_clk (.clk(clk), .rst(rst), .in(ps2_clk), .out(w_clk));
    ps2_filt #(.FILT_CYC(FILT_CYC)) u_filt_dat (.clk(clk), .rst(rst), .in(ps2_dat), .out(w_dat));

    assign w_fall = r_clk_d & ~w_clk;
    assign w_to   = (r_state != IDLE) && (r_tcnt == TW'(TIMEOUT_CYC - 1));
    assign busy   = r_state != IDLE;

    // next-state and next-pulse decode; a falling edge takes priority over a coincident timeout
    always_comb begin
        w_state_n = r_state;
        w_sr_n    = r_sr;
        w_cnt_n   = r_cnt;
        w_p_n     = r_p;
        w_valid_n = 1'b0;
        w_perr_n  = 1'b0;
        w_ferr_n  = 1'b0;
        if (w_fall) begin
            case (r_state)
                IDLE: begin
                    w_state_n = w_dat ? IDLE : DATA;
                    w_cnt_n   = '0;
                    w_ferr_n  = w_dat;
                end
                DATA: begin
                    w_sr_n    = {w_dat, r_sr[7:1]};
                    w_cnt_n   = r_cnt + 3'd1;
                    w_state_n = (r_cnt == 3'(DATA_BITS - 1)) ? PARITY : DATA;
                end
                PARITY: begin
                    w_p_n     = w_dat;
                    w_state_n = STOP;
                end
                STOP: begin
                    w_state_n = IDLE;
                    w_ferr_n  = ~w_dat;
                    w_perr_n  = w_dat & ~^{r_sr, r_p};
                    w_valid_n = w_dat & ^{r_sr, r_p};
                end
                default: w_state_n = IDLE;
            endcase
        end else if (w_to) begin
            w_state_n = IDLE;
            w_ferr_n  = 1'b1;
        end
    end

    // FSM, shift register, edge history and inter-edge timeout counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_p     <= 1'b0;
            r_clk_d <= 1'b1;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_state_n;
            r_sr    <= w_sr_n;
            r_cnt   <= w_cnt_n;
            r_p     <= w_p_n;
            r_clk_d <= w_clk;
            r_tcnt  <= (r_state == IDLE || w_fall) ? '0 : r_tcnt + 1'b1;
        end
    end

    // registered result pulses and byte history
    always_ff @(posedge clk) begin
        if (rst) begin
            valid   <= 1'b0;
            err_par <= 1'b0;
            err_frm <= 1'b0;
            data    <= '0;
            last    <= '0;
        end else begin
            valid   <= w_valid_n;
            err_par <= w_perr_n;
            err_frm <= w_ferr_n;
            if (w_valid_n) begin
                data <= r_sr;
                last <= {last[7:0], r_sr};
            end
        end
    end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed plus randomized frame checks of ps2_rx against a frame-level model
module tb_ps2_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [7:0]  data;
    logic        valid;
    logic        err_par;
    logic        err_frm;
    logic        busy;
    logic [15:0] last;

    int vectors = 0;
    int miscompares = 0;
    int n_valid = 0;
    int n_perr = 0;
    int n_ferr = 0;
    logic [7:0]  exp_data = '0;
    logic [15:0] exp_last = '0;

    ps2_rx #(.FILT_CYC(4), .TIMEOUT_CYC(2000)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .data(data), .valid(valid), .err_par(err_par), .err_frm(err_frm),
        .busy(busy), .last(last)
    );

    always #5 clk = ~clk;

    // running pulse totals, sampled away from the active edge
    always @(negedge clk) begin
        n_valid <= n_valid + int'(valid);
        n_perr  <= n_perr + int'(err_par);
        n_ferr  <= n_ferr + int'(err_frm);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int per, input bit glitch);
        @(negedge clk);
        ps2_dat = b;
        if (glitch) begin
            repeat (per / 8) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (per / 4 - per / 8 - 2) @(negedge clk);
        end else begin
            repeat (per / 4) @(negedge clk);
        end
        ps2_clk = 1'b0;
        repeat (per / 2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (per / 4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                              input int nbits, input int per, input bit glitch);
        logic [10:0] f;
        f = {stop, par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(f[i], per, glitch);
        ps2_dat = 1'b1;
    endtask

    // send a full frame and compare outcome against the frame-level rules
    task automatic frame_check(input string tag, input logic [7:0] b, input logic par,
                               input logic stop, input int per, input bit glitch);
        int v0, p0, f0, ev, ep, ef;
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
        ev = 0;
        ep = 0;
        ef = 0;
        if (!stop) ef = 1;
        else if (^{b, par}) begin
            ev = 1;
            exp_data = b;
            exp_last = {exp_last[7:0], b};
        end else ep = 1;
        send_frame(b, par, stop, 11, per, glitch);
        repeat (20) @(negedge clk);
        chk({tag, ".valid"}, n_valid - v0, ev);
        chk({tag, ".err_par"}, n_perr - p0, ep);
        chk({tag, ".err_frm"}, n_ferr - f0, ef);
        chk({tag, ".data"}, 32'(data), 32'(exp_data));
        chk({tag, ".last"}, 32'(last), 32'(exp_last));
        chk({tag, ".busy"}, 32'(busy), 0);
    endtask

    initial begin
        int f0, v0, p0, k;
        logic [7:0] b;
        logic p;
        repeat (5) @(negedge clk);
        chk("rst.valid", 32'(valid), 0);
        chk("rst.err_par", 32'(err_par), 0);
        chk("rst.err_frm", 32'(err_frm), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.data", 32'(data), 0);
        chk("rst.last", 32'(last), 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        frame_check("f1c", 8'h1C, 1'b0, 1'b1, 800, 1'b0);
        frame_check("ff0", 8'hF0, 1'b1, 1'b1, 800, 1'b0);
        frame_check("fpar", 8'h1C, 1'b1, 1'b1, 800, 1'b0);
        frame_check("fstop", 8'h5A, 1'b1, 1'b0, 800, 1'b0);
        frame_check("f5a", 8'h5A, 1'b1, 1'b1, 800, 1'b0);
        chk("f5a.last_lit", 32'(last), 32'h0000F05A);

        f0 = n_ferr;
        v0 = n_valid;
        send_frame(8'h0F, 1'b1, 1'b1, 5, 800, 1'b0);
        chk("abort.busy_mid", 32'(busy), 1);
        repeat (3000) @(negedge clk);
        chk("abort.err_frm", n_ferr - f0, 1);
        chk("abort.valid", n_valid - v0, 0);
        chk("abort.busy", 32'(busy), 0);
        frame_check("f29", 8'h29, 1'b0, 1'b1, 800, 1'b0);

        f0 = n_ferr;
        @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk);
        chk("idleglitch.err_frm", n_ferr - f0, 0);
        chk("idleglitch.busy", 32'(busy), 0);
        frame_check("fglitch", 8'h1C, 1'b0, 1'b1, 800, 1'b1);

        send_frame(8'h33, 1'b1, 1'b1, 5, 800, 1'b0);
        v0 = n_valid;
        p0 = n_perr;
        f0 = n_ferr;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.data", 32'(data), 0);
        chk("midrst.last", 32'(last), 0);
        rst = 1'b0;
        exp_data = '0;
        exp_last = '0;
        repeat (100) @(negedge clk);
        chk("midrst.pulses", (n_valid - v0) + (n_perr - p0) + (n_ferr - f0), 0);
        frame_check("fpostrst", 8'h1C, 1'b0, 1'b1, 800, 1'b0);

        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            k = int'($urandom_range(0, 3));
            p = (k <= 1) ? ~^b : (k == 2) ? ^b : 1'($urandom);
            frame_check($sformatf("rand%0d", i), b, p, k != 3, 120, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
